// File: rtl/sig_err_sched.sv
// Sequencer for the syndrome/error-index generator: starts one signing attempt,
// collects the accepted error indices across retries, then streams them out.
module sig_err_sched #(
  parameter int MAX_W     = 32,
  parameter int MAX_TRIES = 64,
  parameter int TMO       = 1023
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         req,
  input  logic [177:0] msg_hash,
  output logic         busy,
  output logic         done,
  output logic         fail,
  output logic         syn_start,
  output logic         syn_rst_b,
  output logic [177:0] syn_msg_hash,
  input  logic [1:0]   syn_err_valid,
  input  logic [12:0]  syn_err_idx,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [12:0]  idx_data,
  output logic         idx_last,
  output logic [5:0]   idx_count
);

  localparam int CNT_W = 6;
  localparam int AW    = $clog2(MAX_W);
  localparam int WD_W  = $clog2(TMO + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ARM, S_COLLECT, S_DRAIN, S_ABORT
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   wptr, wptr_n, rptr, rptr_n, rd_nxt, cnt_n;
  logic [TRY_W-1:0]   tries, tries_n;
  logic [WD_W-1:0]    wd, wd_n;
  logic               abort_cnt, abort_n, abort_go;
  logic               code2_p1;
  logic               busy_n, done_n, fail_n, start_n, srst_n, vld_n, last_n, hs;
  logic [177:0]       hash_n;
  logic [12:0]        data_n;
  logic               buf_we;
  logic [AW-1:0]      buf_wa;
  logic [12:0]        idx_buf [MAX_W];

  function automatic logic [TRY_W-1:0] sat_inc_tries(input logic [TRY_W-1:0] v);
    return (v >= TRY_W'(MAX_TRIES + 1)) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_n  = state;
    wptr_n   = wptr;
    rptr_n   = rptr;
    tries_n  = tries;
    wd_n     = wd;
    abort_n  = abort_cnt;
    abort_go = 1'b0;
    busy_n   = busy;
    done_n   = 1'b0;
    fail_n   = 1'b0;
    start_n  = 1'b0;
    srst_n   = 1'b1;
    hash_n   = syn_msg_hash;
    vld_n    = 1'b0;
    data_n   = idx_data;
    last_n   = 1'b0;
    cnt_n    = idx_count;
    buf_we   = 1'b0;
    buf_wa   = wptr[AW-1:0];
    hs       = idx_valid & idx_ready;
    rd_nxt   = rptr + {{(CNT_W-1){1'b0}}, hs};
    unique case (state)
      S_IDLE: begin
        if (req) begin
          hash_n  = msg_hash;
          tries_n = '0;
          wptr_n  = '0;
          rptr_n  = '0;
          wd_n    = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          start_n = 1'b1;
          state_n = S_START;
        end
      end
      S_START: state_n = S_ARM;
      S_ARM: begin
        // The generator shows code 3 while still idle, so only a clear arms us.
        if (syn_err_valid == 2'd2) begin
          tries_n = TRY_W'(1);
          wptr_n  = '0;
          wd_n    = '0;
          state_n = S_COLLECT;
        end
      end
      S_COLLECT: begin
        wd_n = wd + 1'b1;
        if (syn_err_valid == 2'd2 && !code2_p1) begin
          if (tries == TRY_W'(MAX_TRIES)) begin
            abort_go = 1'b1;
          end else begin
            tries_n = sat_inc_tries(tries);
            wptr_n  = '0;
            wd_n    = '0;
          end
        end else if (wd == WD_W'(TMO)) begin
          abort_go = 1'b1;
        end else if (syn_err_valid == 2'd1) begin
          if (wptr == CNT_W'(MAX_W)) begin
            abort_go = 1'b1;
          end else begin
            buf_we = 1'b1;
            wptr_n = wptr + 1'b1;
          end
        end else if (syn_err_valid == 2'd3) begin
          cnt_n   = wptr;
          rptr_n  = '0;
          state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rptr_n = rd_nxt;
        if (rd_nxt < idx_count) begin
          vld_n  = 1'b1;
          data_n = idx_buf[rd_nxt[AW-1:0]];
          last_n = (rd_nxt == idx_count - 1'b1);
        end else begin
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_ABORT: begin
        if (abort_cnt) begin
          abort_n = 1'b0;
          state_n = S_IDLE;
        end else begin
          srst_n  = 1'b0;
          abort_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (abort_go) begin
      state_n = S_ABORT;
      fail_n  = 1'b1;
      busy_n  = 1'b0;
      srst_n  = 1'b0;
      cnt_n   = '0;
      wptr_n  = '0;
      abort_n = 1'b0;
    end
  end

  // Registered control state and outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= S_IDLE;
      wptr         <= '0;
      rptr         <= '0;
      tries        <= '0;
      wd           <= '0;
      abort_cnt    <= 1'b0;
      code2_p1     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      syn_start    <= 1'b0;
      syn_rst_b    <= 1'b0;
      syn_msg_hash <= '0;
      idx_valid    <= 1'b0;
      idx_data     <= '0;
      idx_last     <= 1'b0;
      idx_count    <= '0;
    end else begin
      state        <= state_n;
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      tries        <= tries_n;
      wd           <= wd_n;
      abort_cnt    <= abort_n;
      code2_p1     <= (syn_err_valid == 2'd2);
      busy         <= busy_n;
      done         <= done_n;
      fail         <= fail_n;
      syn_start    <= start_n;
      syn_rst_b    <= srst_n;
      syn_msg_hash <= hash_n;
      idx_valid    <= vld_n;
      idx_data     <= data_n;
      idx_last     <= last_n;
      idx_count    <= cnt_n;
    end
  end

  // Index register file
  always_ff @(posedge clk) begin
    if (buf_we) idx_buf[buf_wa] <= syn_err_idx;
  end

endmodule

// File: tb/tb_sig_err_sched.sv
// Bench for sig_err_sched: a generator model drives codes, a scoreboard queue
// holds the expected stream and is checked beat by beat.
module tb_sig_err_sched;

  localparam int TMO = 1023;

  logic         clk = 1'b0, rst_b = 1'b0, req = 1'b0, idx_ready = 1'b1;
  logic [177:0] msg_hash = '0;
  logic [1:0]   sev = 2'd0;
  logic [12:0]  sidx = '0;
  logic         busy, done, fail, syn_start, syn_rst_b, idx_valid, idx_last;
  logic [177:0] syn_msg_hash;
  logic [12:0]  idx_data;
  logic [5:0]   idx_count;

  int n_chk = 0, n_fail = 0, cyc = 0, bp_mode = 0, ph = 0;
  int n_start = 0, first_vld = -1, last_hs = -1;

  typedef struct { logic [12:0] data; logic last; } beat_t;
  typedef struct { int pre; int n; int base; int bp; int exp_cnt; int exp_lat; } vec_t;
  beat_t q[$];

  sig_err_sched dut (
    .clk(clk), .rst_b(rst_b), .req(req), .msg_hash(msg_hash), .busy(busy), .done(done),
    .fail(fail), .syn_start(syn_start), .syn_rst_b(syn_rst_b), .syn_msg_hash(syn_msg_hash),
    .syn_err_valid(sev), .syn_err_idx(sidx), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx_data(idx_data), .idx_last(idx_last), .idx_count(idx_count)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  initial forever begin
    @(posedge clk); #1;
    ph = ph + 1;
    case (bp_mode)
      1:       idx_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
      2:       idx_ready = 1'b0;
      default: idx_ready = 1'b1;
    endcase
  end

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream monitor / scoreboard
  initial begin
    logic pv, pr;
    logic [12:0] pd;
    beat_t e;
    pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        pv = 1'b0; pr = 1'b0;
      end else begin
        if (syn_start) n_start = n_start + 1;
        if (done || fail) check("done_fail_exclusive", done & fail, 1'b0);
        if (pv && !pr) begin
          check("stall_valid_held", idx_valid, 1'b1);
          check("stall_data_held", idx_data, pd);
        end
        if (idx_valid) begin
          if (first_vld < 0) first_vld = cyc;
          check("valid_has_expected_beat", q.size() != 0, 1'b1);
          if (idx_ready && q.size() != 0) begin
            e = q.pop_front();
            check("beat_data", idx_data, e.data);
            check("beat_last", idx_last, e.last);
            if (e.last) last_hs = cyc;
          end
        end
        pv = idx_valid; pr = idx_ready; pd = idx_data;
      end
    end
  end

  task automatic drive(input logic [1:0] c, input int i);
    @(posedge clk); #1;
    sev = c;
    sidx = 13'(i);
  endtask

  task automatic check_reset_vals();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fail", fail, 1'b0);
    check("rst_syn_start", syn_start, 1'b0);
    check("rst_idx_valid", idx_valid, 1'b0);
    check("rst_idx_last", idx_last, 1'b0);
    check("rst_syn_rst_b", syn_rst_b, 1'b0);
    check("rst_syn_msg_hash", syn_msg_hash, '0);
    check("rst_idx_data", idx_data, '0);
    check("rst_idx_count", idx_count, '0);
  endtask

  task automatic start_job(output logic [177:0] h);
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    h = t[177:0];
    n_start = 0; first_vld = -1; last_hs = -1;
    @(posedge clk); #1;
    req = 1'b1;
    msg_hash = h;
    @(posedge clk); #1;
    req = 1'b0;
    msg_hash = ~h;
    check("syn_start_rise", syn_start, 1'b1);
    check("busy_rise", busy, 1'b1);
  endtask

  task automatic wait_end(input int bound, output int dcyc, output bit gf);
    bit ended;
    ended = 1'b0; gf = 1'b0; dcyc = -1;
    for (int k = 0; k < bound && !ended; k++) begin
      @(negedge clk);
      if (done || fail) begin
        ended = 1'b1; gf = fail; dcyc = cyc;
      end
    end
    check("end_seen", ended, 1'b1);
  endtask

  task automatic abort_check(input string tag, input int dcyc, input int exp_cyc);
    check({tag, "_fail_cycle"}, dcyc, exp_cyc);
    check({tag, "_syn_rst_low1"}, syn_rst_b, 1'b0);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_count_zero"}, idx_count, '0);
    @(negedge clk);
    check({tag, "_fail_width"}, fail, 1'b0);
    check({tag, "_syn_rst_low2"}, syn_rst_b, 1'b0);
    @(negedge clk);
    check({tag, "_syn_rst_release"}, syn_rst_b, 1'b1);
    sev = 2'd3;
  endtask

  task automatic finish_ok(input int exp_cnt, input int dcyc, input bit gf);
    check("no_fail", gf, 1'b0);
    check("busy_at_done", busy, 1'b0);
    check("queue_drained", q.size(), 0);
    check("idx_count", idx_count, exp_cnt);
    check("start_pulses", n_start, 1);
    if (exp_cnt > 0) check("done_after_last", dcyc, last_hs + 1);
    @(negedge clk);
    check("done_width", done, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [177:0] h;
    int d3, dcyc;
    bit gf;
    bp_mode = v.bp;
    for (int i = 0; i < v.n; i++) q.push_back('{data: 13'(v.base + i), last: (i == v.n - 1)});
    start_job(h);
    drive(2'd3, 0);
    for (int i = 0; i < 4; i++) drive(2'd2, 0);
    check("hash_latched", syn_msg_hash, h);
    for (int i = 0; i < 3; i++) drive(2'd0, 0);
    if (v.pre > 0) begin
      for (int i = 0; i < v.pre; i++) drive(2'd1, 50 + i);
      drive(2'd2, 0); drive(2'd2, 0); drive(2'd0, 0);
    end
    for (int i = 0; i < v.n; i++) drive(2'd1, v.base + i);
    drive(2'd3, 0);
    d3 = cyc;
    wait_end(300, dcyc, gf);
    if (v.n > 0) check("first_valid_latency", first_vld, d3 + 2);
    if (v.exp_lat > 0) check("done_latency", dcyc, d3 + v.exp_lat);
    finish_ok(v.exp_cnt, dcyc, gf);
    bp_mode = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    vec_t vt[6];
    logic [177:0] h;
    int a, dcyc;
    bit gf;
    vt[0] = '{0, 20, 0,    0, 20, 22};
    vt[1] = '{5, 12, 100,  0, 12, 14};
    vt[2] = '{0, 7,  500,  1, 7,  0};
    vt[3] = '{0, 0,  0,    0, 0,  2};
    vt[4] = '{3, 32, 8000, 1, 32, 0};
    vt[5] = '{0, 1,  8191, 0, 1,  3};

    #3;
    check_reset_vals();
    @(negedge clk); @(negedge clk); #2;
    rst_b = 1'b1;
    check("syn_rst_b_before_edge", syn_rst_b, 1'b0);
    @(posedge clk); #1;
    check("syn_rst_b_after_edge", syn_rst_b, 1'b1);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Overflow: 33 indices into a 32-deep buffer
    start_job(h);
    drive(2'd2, 0); drive(2'd2, 0);
    for (int i = 0; i < 33; i++) drive(2'd1, i);
    a = cyc;
    wait_end(50, dcyc, gf);
    check("ovf_fail", gf, 1'b1);
    abort_check("ovf", dcyc, a + 1);

    // Try limit: 65 clear entries
    start_job(h);
    for (int i = 0; i < 65; i++) begin
      if (i > 0) drive(2'd0, 0);
      drive(2'd2, 0);
    end
    a = cyc;
    wait_end(50, dcyc, gf);
    check("tries_fail", gf, 1'b1);
    abort_check("tries", dcyc, a + 1);

    // Stuck generator
    start_job(h);
    drive(2'd2, 0);
    a = cyc;
    drive(2'd0, 0);
    wait_end(TMO + 50, dcyc, gf);
    check("tmo_fail", gf, 1'b1);
    abort_check("tmo", dcyc, a + TMO + 2);

    // Clear arriving exactly when the watchdog reaches TMO
    q.push_back('{data: 13'd7, last: 1'b0});
    q.push_back('{data: 13'd9, last: 1'b1});
    start_job(h);
    drive(2'd2, 0);
    for (int j = 1; j <= TMO; j++) drive(2'd0, 0);
    drive(2'd2, 0);
    drive(2'd0, 0); drive(2'd1, 7); drive(2'd1, 9); drive(2'd3, 0);
    wait_end(50, dcyc, gf);
    finish_ok(2, dcyc, gf);

    // Asynchronous reset while draining
    bp_mode = 2;
    for (int i = 0; i < 10; i++) q.push_back('{data: 13'(1000 + i), last: (i == 9)});
    start_job(h);
    drive(2'd3, 0); drive(2'd2, 0);
    for (int i = 0; i < 10; i++) drive(2'd1, 1000 + i);
    drive(2'd3, 0);
    for (int k = 0; k < 20 && !idx_valid; k++) @(negedge clk);
    check("drain_valid_seen", idx_valid, 1'b1);
    #2;
    rst_b = 1'b0;
    #1;
    check_reset_vals();
    q.delete();
    bp_mode = 0;
    @(negedge clk); #2;
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("syn_rst_b_after_rerelease", syn_rst_b, 1'b1);
    run_vec(vt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
